// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Instruction fetch front end. It owns the program counter (PC) and the
//   instruction register (INS), and it sequences single-word reads from a
//   synchronous instruction memory that returns data one cycle after the read
//   enable. A three-state FSM (IDLE / RD / HOLD) tracks the read.
//   - In RD the memory word is bypassed straight to fetchData.
//   - In HOLD the word is replayed from a hold register, so the controller can
//     capture it into IR or AR on any later cycle.
//   A sticky fetchErr flag records protocol misuse: a read request while a
//   read is already in flight, or an IR write with no valid word.
//
// Ports:
//   Clk        in   sole clock, rising edge
//   Rst        in   synchronous active-high reset, overrides every other input
//   insRead    in   fetch request from the controller
//   incPC      in   PC increment strobe
//   loadPC     in   PC load-from-bus strobe (wins over incPC)
//   irWrite    in   IR write strobe
//   busIn      in   [ADDR_W] datapath bus value for a PC load
//   imemRd     out  instruction memory read enable
//   imemAddr   out  [ADDR_W] instruction memory address (always equals PC)
//   imemData   in   [DATA_W] memory read data, valid one cycle after imemRd
//   fetchData  out  [DATA_W] fetched word for IR / AR capture
//   fetchValid out  fetchData holds a valid word
//   INS        out  [DATA_W] instruction register contents
//   PC         out  [ADDR_W] program counter
//   fetchErr   out  sticky protocol-error flag, cleared only by Rst
//
// Optional feature, controlled by macro FETCH_HALT_EN:
//   Loading an all-ones word into IR halts the unit. While halted, read
//   requests and PC updates are ignored until Rst. Without the macro, an
//   all-ones word is an ordinary instruction.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              insRead,
    input  logic              incPC,
    input  logic              loadPC,
    input  logic              irWrite,
    input  logic [ADDR_W-1:0] busIn,
    output logic              imemRd,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic [DATA_W-1:0] imemData,
    output logic [DATA_W-1:0] fetchData,
    output logic              fetchValid,
    output logic [DATA_W-1:0] INS,
    output logic [ADDR_W-1:0] PC,
    output logic              fetchErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [DATA_W-1:0] holdWord;

`ifdef FETCH_HALT_EN
    logic halted;

    // Halt latches when an all-ones word is actually written into IR.
    // Only Rst clears it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            halted <= 1'b0;
        end else if (irWrite && fetchValid && (fetchData == {DATA_W{1'b1}})) begin
            halted <= 1'b1;
        end
    end
`else
    localparam logic halted = 1'b0;
`endif

    // The memory address is always the current (pre-update) PC. A PC
    // change in the same cycle as a read therefore does not move that read.
    assign imemAddr = PC;

    // Next-state and output decode. The read enable is combinational so the
    // request and the memory access happen in the same cycle. Reset forces
    // all fetch outputs quiet during the reset cycle itself.
    always_comb begin
        stateNext  = state;
        imemRd     = 1'b0;
        fetchValid = 1'b0;
        fetchData  = '0;
        case (state)
            IDLE: begin
                if (insRead && !halted) begin
                    imemRd    = 1'b1;
                    stateNext = RD;
                end
            end
            RD: begin
                fetchValid = 1'b1;
                fetchData  = imemData;
                stateNext  = HOLD;
            end
            HOLD: begin
                fetchValid = 1'b1;
                fetchData  = holdWord;
                if (insRead && !halted) begin
                    imemRd    = 1'b1;
                    stateNext = RD;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (Rst) begin
            imemRd     = 1'b0;
            fetchValid = 1'b0;
            fetchData  = '0;
            stateNext  = IDLE;
        end
    end

    // State, PC, IR, hold register and error flag.
    // - IR captures whatever fetchData shows this cycle. In HOLD with a
    //   simultaneous new read, that is still the old hold word.
    // - A request arriving while a read is in flight is dropped and
    //   flagged as an error.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            PC       <= '0;
            INS      <= '0;
            holdWord <= '0;
            fetchErr <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == RD) begin
                holdWord <= imemData;
            end
            if (!halted) begin
                if (loadPC) begin
                    PC <= busIn;
                end else if (incPC) begin
                    PC <= PC + ADDR_W'(1);
                end
            end
            if (irWrite) begin
                if (fetchValid) begin
                    INS <= fetchData;
                end else begin
                    fetchErr <= 1'b1;
                end
            end
            if ((state == RD) && insRead && !halted) begin
                fetchErr <= 1'b1;
            end
        end
    end

endmodule
